flag_unit: RTL and testbench

Registered NZCV flag unit for the ALU datapath. It is the parametrised successor to the combinational flag selector and adds four things:
- holds the flags in a register, updated only by instructions that pass their condition check;
- evaluates a 3-bit condition code against the held flags;
- keeps C/V across multiply instead of zeroing them;
- provides a LIFO flag-save stack for interrupt entry and return.

It sits between the ALU result stage and the issue/branch logic.

---
 rtl/flag_unit_pkg.sv | 41 ++++
 rtl/flag_stack.sv | 58 +++++
 rtl/flag_unit.sv | 95 +++++++++
 tb/tb_flag_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/flag_unit_pkg.sv
// Shared constants and condition evaluation for the NZCV flag unit.
package flag_unit_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_CMP = 4'd11;

  localparam logic [2:0] CC_AL = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_GE = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_NE = 3'b100;
  localparam logic [2:0] CC_CS = 3'b101;
  localparam logic [2:0] CC_CC = 3'b110;
  localparam logic [2:0] CC_GT = 3'b111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Evaluate a condition code against a {N,Z,C,V} flag vector.
  function automatic logic cond_eval(input logic [2:0] cc, input logic [3:0] f);
    logic res;
    res = 1'b1;
    case (cc)
      CC_AL: res = 1'b1;
      CC_EQ: res = f[FLAG_Z];
      CC_GE: res = (f[FLAG_N] == f[FLAG_V]);
      CC_LT: res = (f[FLAG_N] != f[FLAG_V]);
      CC_NE: res = !f[FLAG_Z];
      CC_CS: res = f[FLAG_C];
      CC_CC: res = !f[FLAG_C];
      CC_GT: res = !f[FLAG_Z] && (f[FLAG_N] == f[FLAG_V]);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/flag_stack.sv
// Parametrised LIFO used to save/restore flags around interrupts; sticky error on misuse.
module flag_stack #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             restore_c,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             push_ok;
  logic             err_set;

  // Simultaneous push and pop is treated as a conflict and both are dropped.
  always_comb begin
    push_ok   = push && !pop && !full;
    restore_c = pop && !push && !empty;
    err_set   = (push && pop) || (push && !pop && full) || (pop && !push && empty);
    count_nxt = count;
    if (push_ok)   count_nxt = count + CW'(1);
    if (restore_c) count_nxt = count - CW'(1);
    dout = empty ? '0 : mem[AW'(count - CW'(1))];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      err   <= 1'b0;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
      err   <= err_set || (err && !err_clr);
    end
  end

  // Storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[AW'(count)] <= din;
  end

endmodule

// File: rtl/flag_unit.sv
// Registered NZCV flags with condition evaluation and an interrupt flag-save stack.
module flag_unit
  import flag_unit_pkg::*;
#(
  parameter int unsigned DATA_W         = 16,
  parameter bit          MUL_SETS_FLAGS = 1'b0,
  parameter int unsigned STACK_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [3:0]        opcode,
  input  logic [2:0]        cond_code,
  input  logic [DATA_W-1:0] result,
  input  logic              ovf_add,
  input  logic              c_add,
  input  logic              ovf_sub,
  input  logic              c_sub,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  output logic [3:0]        flags_q,
  output logic              cond_pass,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  logic [3:0] flags_upd;
  logic [3:0] stack_dout;
  logic       restore_c;
  logic       set_nz;
  logic       sel_add;
  logic       sel_sub;
  logic       fire;

  assign cond_pass = cond_eval(cond_code, flags_q);

  // Decode which flag fields the retiring instruction writes; MUL leaves C/V alone.
  always_comb begin
    set_nz    = 1'b0;
    sel_add   = 1'b0;
    sel_sub   = 1'b0;
    flags_upd = flags_q;
    case (opcode)
      OP_ADD: begin set_nz = 1'b1; sel_add = 1'b1; end
      OP_SUB,
      OP_CMP: begin set_nz = 1'b1; sel_sub = 1'b1; end
      OP_MUL: set_nz = MUL_SETS_FLAGS;
      default: ;
    endcase
    if (set_nz) begin
      flags_upd[FLAG_N] = result[DATA_W-1];
      flags_upd[FLAG_Z] = (result == '0);
    end
    if (sel_add) begin
      flags_upd[FLAG_C] = c_add;
      flags_upd[FLAG_V] = ovf_add;
    end
    if (sel_sub) begin
      flags_upd[FLAG_C] = c_sub;
      flags_upd[FLAG_V] = ovf_sub;
    end
    fire = valid && cond_pass && set_nz;
  end

  // A successful pop takes priority over any instruction update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (restore_c) begin
      flags_q <= stack_dout;
    end else if (fire) begin
      flags_q <= flags_upd;
    end
  end

  flag_stack #(
    .WIDTH (4),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .err_clr   (err_clr),
    .din       (flags_q),
    .dout      (stack_dout),
    .restore_c (restore_c),
    .full      (stack_full),
    .empty     (stack_empty),
    .err       (stack_err)
  );

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit; two instances differ only in MUL_SETS_FLAGS.
module tb_flag_unit;
  import flag_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [3:0]  opcode;
  logic [2:0]  cond_code;
  logic [15:0] result;
  logic        ovf_add, c_add, ovf_sub, c_sub;
  logic        push, pop, err_clr;

  logic [3:0] a_flags, b_flags;
  logic       a_pass, b_pass;
  logic       a_full, b_full, a_empty, b_empty, a_err, b_err;

  int errors = 0;
  int checks = 0;

  flag_unit #(.DATA_W(16), .MUL_SETS_FLAGS(1'b1), .STACK_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid(valid), .opcode(opcode), .cond_code(cond_code),
    .result(result), .ovf_add(ovf_add), .c_add(c_add), .ovf_sub(ovf_sub), .c_sub(c_sub),
    .push(push), .pop(pop), .err_clr(err_clr), .flags_q(a_flags), .cond_pass(a_pass),
    .stack_full(a_full), .stack_empty(a_empty), .stack_err(a_err)
  );

  flag_unit #(.DATA_W(16), .MUL_SETS_FLAGS(1'b0), .STACK_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid(valid), .opcode(opcode), .cond_code(cond_code),
    .result(result), .ovf_add(ovf_add), .c_add(c_add), .ovf_sub(ovf_sub), .c_sub(c_sub),
    .push(push), .pop(pop), .err_clr(err_clr), .flags_q(b_flags), .cond_pass(b_pass),
    .stack_full(b_full), .stack_empty(b_empty), .stack_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic idle();
    valid = 1'b0; opcode = 4'hf; cond_code = CC_AL; result = '0;
    ovf_add = 1'b0; c_add = 1'b0; ovf_sub = 1'b0; c_sub = 1'b0;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  // Drives an ALU op; the unused carry/overflow pair is inverted to expose a wrong source.
  task automatic alu(input logic [3:0] op, input logic [15:0] res, input logic c, input logic v);
    valid = 1'b1; opcode = op; result = res;
    if (op == OP_ADD) begin
      c_add = c; ovf_add = v; c_sub = !c; ovf_sub = !v;
    end else begin
      c_sub = c; ovf_sub = v; c_add = !c; ovf_add = !v;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] p_res  [5] = '{16'h0001, 16'h0000, 16'h8000, 16'h0000, 16'h8000};
  logic        p_c    [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic        p_v    [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [3:0]  p_exp  [5] = '{4'b0001, 4'b0110, 4'b1000, 4'b0111, 4'b1010};
  logic [3:0]  pop_exp[4] = '{4'b1000, 4'b0110, 4'b0001, 4'b1011};

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    check("rst_flags", 8'(a_flags), 8'h0);
    check("rst_empty", 8'(a_empty), 8'h1);
    check("rst_full",  8'(a_full),  8'h0);
    check("rst_err",   8'(a_err),   8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    alu(OP_ADD, 16'h8000, 1'b1, 1'b1); tick(); idle();
    check("add_flags", 8'(a_flags), 8'b1011);
    alu(OP_CMP, 16'h0000, 1'b1, 1'b0); tick(); idle();
    check("cmp_flags", 8'(a_flags), 8'b0110);
    cond_code = CC_EQ; #1 check("cc_eq", 8'(a_pass), 8'h1);
    cond_code = CC_LT; #1 check("cc_lt", 8'(a_pass), 8'h0);
    cond_code = CC_GT; #1 check("cc_gt", 8'(a_pass), 8'h0);
    cond_code = CC_CS; #1 check("cc_cs", 8'(a_pass), 8'h1);
    cond_code = CC_GE; #1 check("cc_ge", 8'(a_pass), 8'h1);
    cond_code = CC_CC; #1 check("cc_cc", 8'(a_pass), 8'h0);
    idle();

    alu(OP_ADD, 16'h0001, 1'b1, 1'b0); tick(); idle();
    check("pre_mul_a", 8'(a_flags), 8'b0010);
    alu(OP_MUL, 16'h0000, 1'b0, 1'b0); tick(); idle();
    check("mul_sets_a", 8'(a_flags), 8'b0110);
    check("mul_hold_b", 8'(b_flags), 8'b0010);
    alu(OP_SUB, 16'h0000, 1'b0, 1'b0); tick(); idle();
    check("sub_a", 8'(a_flags), 8'b0100);
    check("sub_b", 8'(b_flags), 8'b0100);

    alu(OP_SUB, 16'hffff, 1'b1, 1'b1); cond_code = CC_NE; #1;
    check("ne_pass", 8'(a_pass), 8'h0);
    tick();
    check("ne_hold", 8'(a_flags), 8'b0100);
    cond_code = CC_EQ; #1;
    check("eq_pass", 8'(a_pass), 8'h1);
    tick(); idle();
    check("eq_upd", 8'(a_flags), 8'b1011);

    for (int i = 0; i < 5; i++) begin
      push = 1'b1; alu(OP_ADD, p_res[i], p_c[i], p_v[i]); tick(); idle();
      check($sformatf("push%0d_flags", i), 8'(a_flags), 8'(p_exp[i]));
      check($sformatf("push%0d_full", i), 8'(a_full), (i >= 3) ? 8'h1 : 8'h0);
      check($sformatf("push%0d_err", i), 8'(a_err), (i == 4) ? 8'h1 : 8'h0);
    end
    for (int i = 0; i < 4; i++) begin
      pop = 1'b1;
      if (i == 0) alu(OP_ADD, 16'h0000, 1'b1, 1'b1);
      tick(); idle();
      check($sformatf("pop%0d_flags", i), 8'(a_flags), 8'(pop_exp[i]));
      check($sformatf("pop%0d_empty", i), 8'(a_empty), (i == 3) ? 8'h1 : 8'h0);
    end
    check("pop_full", 8'(a_full), 8'h0);

    err_clr = 1'b1; tick(); idle();
    check("clr_err", 8'(a_err), 8'h0);
    pop = 1'b1; err_clr = 1'b1; alu(OP_ADD, 16'h0000, 1'b0, 1'b0); tick(); idle();
    check("under_err", 8'(a_err), 8'h1);
    check("under_flags", 8'(a_flags), 8'b0100);
    check("under_empty", 8'(a_empty), 8'h1);

    push = 1'b1; alu(OP_ADD, 16'h8000, 1'b1, 1'b1); tick(); idle();
    check("one_flags", 8'(a_flags), 8'b1011);
    check("one_empty", 8'(a_empty), 8'h0);
    err_clr = 1'b1; tick(); idle();
    check("clr2_err", 8'(a_err), 8'h0);
    push = 1'b1; pop = 1'b1; tick(); idle();
    check("pp_err", 8'(a_err), 8'h1);
    check("pp_empty", 8'(a_empty), 8'h0);
    check("pp_flags", 8'(a_flags), 8'b1011);
    pop = 1'b1; tick(); idle();
    check("pp_pop_flags", 8'(a_flags), 8'b0100);
    check("pp_pop_empty", 8'(a_empty), 8'h1);
    err_clr = 1'b1; tick(); idle();
    check("clr3_err", 8'(a_err), 8'h0);

    push = 1'b1; alu(OP_ADD, 16'h8000, 1'b1, 1'b1); tick(); idle();
    push = 1'b1; alu(OP_ADD, 16'h0000, 1'b1, 1'b1); tick(); idle();
    push = 1'b1; tick(); idle();
    push = 1'b1; pop = 1'b1; tick(); idle();
    check("pre_rst_flags", 8'(a_flags), 8'b0111);
    check("pre_rst_err", 8'(a_err), 8'h1);
    check("pre_rst_empty", 8'(a_empty), 8'h0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_flags_a", 8'(a_flags), 8'h0);
    check("arst_flags_b", 8'(b_flags), 8'h0);
    check("arst_empty", 8'(a_empty), 8'h1);
    check("arst_full", 8'(a_full), 8'h0);
    check("arst_err", 8'(a_err), 8'h0);
    #3 rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
